// File: rtl/tag_ram_pkg.sv
// rtl/tag_ram_pkg.sv - shared op encodings, FSM states and tag compare for the tag RAM controller
package tag_ram_pkg;

   localparam int unsigned TAG_DWIDTH = 9;
   localparam int unsigned VALID_BIT  = TAG_DWIDTH - 1;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'b00,
      OP_FILL   = 2'b01,
      OP_INVAL  = 2'b10,
      OP_LKFILL = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_START,
      ST_INIT,
      ST_IDLE,
      ST_CMP,
      ST_WR,
      ST_RSP
   } state_e;

   // Tags are zero-extended to 32 bits by the caller so one function serves any width.
   function automatic logic tag_hit(input logic vld, input logic [31:0] stored_tag,
                                    input logic [31:0] want_tag);
      return vld && (stored_tag == want_tag);
   endfunction

endpackage

// File: rtl/tag_ram_ctrl_if.sv
// rtl/tag_ram_ctrl_if.sv - request/response handshake between cache pipeline and tag RAM controller
interface tag_ram_ctrl_if #(
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned DWIDTH = 9
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [AWIDTH-1:0] req_index;
   logic [DWIDTH-2:0] req_tag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_hit;
   logic [DWIDTH-1:0] rsp_word;

   modport master (
      output req_valid, req_op, req_index, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_word
   );

   modport slave (
      input  req_valid, req_op, req_index, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_word
   );
endinterface

// File: rtl/tag_ram_ctrl.sv
// rtl/tag_ram_ctrl.sv - clears the tag RAM after reset, then serialises lookup/fill/inval/lkfill requests
module tag_ram_ctrl
   import tag_ram_pkg::*;
#(
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned DWIDTH = VALID_BIT + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   tag_ram_ctrl_if.slave     bus,
   output logic              init_done,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout
);

   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
   logic              init_done_q, init_done_d;
   op_e               op_q, op_d;
   logic [AWIDTH-1:0] index_q, index_d;
   logic [DWIDTH-2:0] tag_q, tag_d;
   logic              rsp_hit_q, rsp_hit_d;
   logic [DWIDTH-1:0] rsp_word_q, rsp_word_d;

   logic req_ready_c;
   logic rsp_valid_c;
   logic hit_c;

   assign hit_c = tag_hit(ram_dout[DWIDTH-1], 32'(ram_dout[DWIDTH-2:0]), 32'(tag_q));

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      op_d        = op_q;
      index_d     = index_q;
      tag_d       = tag_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_word_d  = rsp_word_q;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      ram_we      = 1'b0;
      ram_din     = '0;
      ram_addr    = index_q;

      case (state_q)
         ST_START: state_d = ST_INIT;

         ST_INIT: begin
            ram_we   = 1'b1;
            ram_addr = init_cnt_q;
            if (init_cnt_q == LAST_IDX) begin
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               init_cnt_d = init_cnt_q + AWIDTH'(1);
            end
         end

         ST_IDLE: begin
            req_ready_c = 1'b1;
            // Present the incoming index so the RAM samples it on the accept edge.
            ram_addr    = bus.req_index;
            if (bus.req_valid) begin
               op_d    = op_e'(bus.req_op);
               index_d = bus.req_index;
               tag_d   = bus.req_tag;
               if (op_e'(bus.req_op) == OP_LOOKUP || op_e'(bus.req_op) == OP_LKFILL) begin
                  state_d = ST_CMP;
               end else begin
                  state_d = ST_WR;
               end
            end
         end

         ST_CMP: begin
            rsp_hit_d  = hit_c;
            rsp_word_d = ram_dout;
            state_d    = (op_q == OP_LKFILL && !hit_c) ? ST_WR : ST_RSP;
         end

         ST_WR: begin
            ram_we  = 1'b1;
            ram_din = {op_q != OP_INVAL, tag_q};
            // An allocating miss reports what the lookup saw, not what was written.
            if (op_q != OP_LKFILL) begin
               rsp_hit_d  = 1'b0;
               rsp_word_d = '0;
            end
            state_d = ST_RSP;
         end

         ST_RSP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_START;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_START;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         op_q        <= OP_LOOKUP;
         index_q     <= '0;
         tag_q       <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_word_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         op_q        <= op_d;
         index_q     <= index_d;
         tag_q       <= tag_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_word_q  <= rsp_word_d;
      end
   end

   assign init_done     = init_done_q;
   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_word  = rsp_word_q;

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// tb/tb_tag_ram_ctrl.sv - directed bench for tag_ram_ctrl with a synchronous-read RAM model alongside
module tb_tag_ram_ctrl;
   import tag_ram_pkg::*;

   localparam int unsigned AWIDTH = 3;
   localparam int unsigned DWIDTH = 9;
   localparam int unsigned DEPTH  = 1 << AWIDTH;

   logic              clock;
   logic              reset_n;
   logic              init_done;
   logic [AWIDTH-1:0] ram_addr;
   logic [DWIDTH-1:0] ram_din;
   logic              ram_we;
   logic [DWIDTH-1:0] ram_dout;

   int n_checks = 0;
   int n_fail   = 0;

   tag_ram_ctrl_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

   tag_ram_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .init_done (init_done),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] raddr_q;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 9'h1C0 | 9'(i);
      raddr_q = '0;
   end

   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      raddr_q <= ram_addr;
   end
   assign ram_dout = mem[raddr_q];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_clear(input string name);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         check($sformatf("%s_we%0d", name, c), 32'(ram_we), (c <= 8) ? 1 : 0);
         if (c <= 8) begin
            check($sformatf("%s_addr%0d", name, c), 32'(ram_addr), 32'(c - 1));
            check($sformatf("%s_din%0d", name, c), 32'(ram_din), 0);
         end
         check($sformatf("%s_done%0d", name, c), 32'(init_done), (c >= 9) ? 1 : 0);
         check($sformatf("%s_rdy%0d", name, c), 32'(bus.req_ready), (c >= 9) ? 1 : 0);
      end
   endtask

   task automatic do_req(input string name, input logic [1:0] op, input logic [AWIDTH-1:0] idx,
                         input logic [DWIDTH-2:0] tg, input int exp_lat, input logic exp_hit,
                         input logic [DWIDTH-1:0] exp_word);
      int w;
      int lat;
      @(negedge clock);
      bus.req_op    = op;
      bus.req_index = idx;
      bus.req_tag   = tg;
      bus.req_valid = 1'b1;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(negedge clock);
         w++;
      end
      check({name, "_ready"}, 32'(bus.req_ready), 1);
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clock);
         lat++;
         if (bus.rsp_valid) break;
      end
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
      check({name, "_word"}, 32'(bus.rsp_word), 32'(exp_word));
      @(posedge clock);
      #1 check({name, "_vdrop"}, 32'(bus.rsp_valid), 0);
   endtask

   initial begin
      int w;
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_index = '0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b1;

      repeat (3) @(negedge clock);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_hit", 32'(bus.rsp_hit), 0);
      check("rst_rsp_word", 32'(bus.rsp_word), 0);
      check("rst_init_done", 32'(init_done), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_ram_din", 32'(ram_din), 0);
      reset_n = 1'b1;
      check_clear("clr");

      do_req("fill3", OP_FILL, 3'd3, 8'h5A, 2, 1'b0, 9'h000);
      do_req("look3_hit", OP_LOOKUP, 3'd3, 8'h5A, 2, 1'b1, 9'h15A);
      do_req("look3_miss", OP_LOOKUP, 3'd3, 8'h5B, 2, 1'b0, 9'h15A);
      do_req("lkf6_miss", OP_LKFILL, 3'd6, 8'h21, 3, 1'b0, 9'h000);
      do_req("lkf6_hit", OP_LKFILL, 3'd6, 8'h21, 2, 1'b1, 9'h121);
      do_req("inval3", OP_INVAL, 3'd3, 8'h00, 2, 1'b0, 9'h000);
      do_req("look3_inv", OP_LOOKUP, 3'd3, 8'h5A, 2, 1'b0, 9'h000);

      // Back-pressure with a second request waiting behind the held response.
      bus.rsp_ready = 1'b0;
      @(negedge clock);
      bus.req_op    = OP_LOOKUP;
      bus.req_index = 3'd6;
      bus.req_tag   = 8'h21;
      bus.req_valid = 1'b1;
      check("bp_ready", 32'(bus.req_ready), 1);
      @(posedge clock);
      #1;
      bus.req_index = 3'd3;
      bus.req_tag   = 8'h5A;
      w = 0;
      while (!bus.rsp_valid && w < 10) begin
         @(negedge clock);
         w++;
      end
      check("bp_lat", 32'(w), 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 1);
         check($sformatf("bp_hit%0d", i), 32'(bus.rsp_hit), 1);
         check($sformatf("bp_word%0d", i), 32'(bus.rsp_word), 32'h121);
         check($sformatf("bp_rdy%0d", i), 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clock);
      #1 check("bp_vdrop", 32'(bus.rsp_valid), 0);
      @(negedge clock);
      check("bp_ready_back", 32'(bus.req_ready), 1);

      // Reset while the FILL is in WR: write and response must both be lost.
      @(negedge clock);
      bus.req_op    = OP_FILL;
      bus.req_index = 3'd2;
      bus.req_tag   = 8'h44;
      bus.req_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      check("wr_we_pre", 32'(ram_we), 1);
      #2 reset_n = 1'b0;
      #1;
      check("wr_rst_we", 32'(ram_we), 0);
      check("wr_rst_valid", 32'(bus.rsp_valid), 0);
      check("wr_rst_ready", 32'(bus.req_ready), 0);
      check("wr_rst_done", 32'(init_done), 0);
      check("wr_rst_addr", 32'(ram_addr), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("wr_rst_norsp%0d", i), 32'(bus.rsp_valid), 0);
      end
      reset_n = 1'b1;
      check_clear("reclr");
      do_req("post_look6", OP_LOOKUP, 3'd6, 8'h21, 2, 1'b0, 9'h000);
      do_req("post_look2", OP_LOOKUP, 3'd2, 8'h44, 2, 1'b0, 9'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tag_ram_ctrl.md
# tag_ram_ctrl

Initiator-side controller for the team's synchronous-read cache tag RAM (registered read address, one-cycle read latency, write on `we`). It clears the RAM after reset, then serialises lookup, fill, invalidate and lookup-with-allocate requests from the cache pipeline. It drives the RAM's `addr`/`din`/`we` port, compares returned tag words, and returns hit/miss responses over a valid/ready handshake.

## Interface
- `AWIDTH`, 3, index width; `DEPTH = 1 << AWIDTH` entries.
- `DWIDTH`, 9, tag-word width; bit `DWIDTH-1` = valid, bits `[DWIDTH-2:0]` = tag.
- `clock` in 1: the single clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts; transfer when `req_valid & req_ready` at a posedge.
- `req_op` in 2: 00 LOOKUP, 01 FILL, 10 INVAL, 11 LKFILL (lookup; allocate on miss).
- `req_index` in AWIDTH: entry index.
- `req_tag` in DWIDTH-1: tag to compare or write.
- `rsp_valid` out 1: response present; held until taken.
- `rsp_ready` in 1: consumer takes response.
- `rsp_hit` out 1: lookup hit; 0 for FILL/INVAL.
- `rsp_word` out DWIDTH: stored word read by LOOKUP/LKFILL; 0 for FILL/INVAL.
- `init_done` out 1: RAM clear complete; stays 1 until reset.
- `ram_addr` out AWIDTH, `ram_din` out DWIDTH, `ram_we` out 1: RAM port.
- `ram_dout` in DWIDTH: RAM read data, valid the cycle after `ram_addr` is sampled.

## Operation
- States: START, INIT, IDLE, CMP, WR, RSP.
- START: reset state; `ram_we=0`; next edge → INIT.
- INIT: `ram_we=1`, `ram_din=0`, `ram_addr=init_cnt`. The counter runs 0..DEPTH-1. After writing DEPTH-1: `init_done←1`, → IDLE. No wrap; the counter is unused afterwards.
- IDLE: `req_ready=1`, `ram_addr=req_index`, so the RAM latches the index on the accept edge. On accept, latch op/index/tag:
  - LOOKUP/LKFILL → CMP.
  - FILL/INVAL → WR.
- Outside IDLE: `req_ready=0`; `ram_addr` = latched index (INIT excepted).
- CMP: `hit = ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0] == tag)`. Register `rsp_hit` and `rsp_word=ram_dout`.
  - LKFILL & miss → WR.
  - Otherwise → RSP.
- WR: `ram_we=1`, `ram_din = {op!=INVAL, tag}` → RSP. For FILL/INVAL, `rsp_hit=0` and `rsp_word=0`. LKFILL-miss keeps the CMP values.
- RSP: `rsp_valid=1` until `rsp_ready`; on the taking edge → IDLE and `rsp_valid` drops.
- `ram_we=0` in every state except INIT and WR.
- Reset asserted at any time: immediate return to START, all outputs at reset values, full re-clear. An in-flight request is dropped with no response.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_hit=0`, `rsp_word=0`, `init_done=0`, `ram_we=0`, `ram_addr=0`, `ram_din=0`.
- Clear: `init_done` rises DEPTH+1 edges after reset release (9 for AWIDTH=3).
- Accept at edge n; `rsp_valid` high from:
  - edge n+2 for LOOKUP, LKFILL-hit, FILL and INVAL;
  - edge n+3 for LKFILL-miss.
- RAM write commits at the edge leaving WR, which is always before `rsp_valid`. A following request to the same index therefore reads the new word.
- Peak throughput: one request per 3 cycles with `rsp_ready` tied high. `req_ready` rises the cycle after the response is taken.
- `req_*` and `rsp_ready` are sampled only at posedge. Input changes while not ready are ignored.

## Structure
- Package `tag_ram_pkg`:
  - op encodings `OP_LOOKUP`/`OP_FILL`/`OP_INVAL`/`OP_LKFILL`;
  - state enum;
  - bit-position constant for the valid bit;
  - a pure tag-compare function.
- No sub-module. The RAM is instantiated beside the controller, not inside it; the bench wires them together.

## Test plan
- Reset release → `ram_we` high for exactly 8 cycles at addr 0..7 with din 0, then `init_done=1` and `req_ready=1`.
- FILL idx 3 tag 0x5A, then LOOKUP idx 3 tag 0x5A → `rsp_hit=1`, `rsp_word=0x15A`. LOOKUP idx 3 tag 0x5B → `rsp_hit=0`, `rsp_word=0x15A`.
- LKFILL idx 6 tag 0x21 on an empty entry → `rsp_hit=0` at n+3. Repeat → `rsp_hit=1` at n+2, `rsp_word=0x121`.
- INVAL idx 3, then LOOKUP idx 3 tag 0x5A → `rsp_hit=0`, `rsp_word=0x000`.
- Hold `rsp_ready=0` for 5 cycles → `rsp_valid`/`rsp_hit`/`rsp_word` stable and `req_ready=0` throughout, with `req_valid` held high.
- Assert `reset_n` low while in WR → `ram_we` drops immediately, no response. After release, the full 8-entry re-clear runs and a LOOKUP of the previously filled index misses.
